// File: rtl/fp_rf_pkg.sv
// Shared defaults and floating-point constants for the FP register file.
package fp_rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int PEND_W_DEF = 2;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/fp_pend_ctr.sv
// Pending-writer counter for one FP register.
// Saturates at all-ones and does not go below zero.
// Increment and decrement in the same cycle cancel each other.
module fp_pend_ctr
  import fp_rf_pkg::*;
#(
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [PEND_W-1:0] o_cnt,
  output logic              o_sat,
  output logic              o_zero,
  output logic              o_underflow
);

  logic [PEND_W-1:0] r_cnt;

  assign o_cnt       = r_cnt;
  assign o_sat       = &r_cnt;
  assign o_zero      = (r_cnt == '0);
  assign o_underflow = i_dec & ~i_inc & o_zero;

  // Count issues up and writebacks down; simultaneous inc/dec holds the value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && !o_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && !o_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fp_reg_file_sb.sv
// FP register file with a pending-write scoreboard.
// Reads are combinational with an optional WB->ID bypass. Each register
// has a pending-writer counter that drives operand-ready and issue-accept.
module fp_reg_file_sb
  import fp_rf_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int PEND_W     = PEND_W_DEF,
  parameter bit FORWARD_EN = 1'b1,
  parameter bit ZERO_R0    = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr_1,
  input  logic [ADDR_W-1:0] i_rd_addr_2,
  output logic [DATA_W-1:0] o_rd_data_1,
  output logic [DATA_W-1:0] o_rd_data_2,
  output logic              o_rd_rdy_1,
  output logic              o_rd_rdy_2,
  input  logic              i_iss_en,
  input  logic [ADDR_W-1:0] i_iss_addr,
  output logic              o_iss_ok,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_err
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_err;

  logic [PEND_W-1:0]   w_pend [NUM_REGS];
  logic [NUM_REGS-1:0] w_sat;
  logic [NUM_REGS-1:0] w_zero;
  logic [NUM_REGS-1:0] w_unf;
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic                w_wb_eff;
  logic                w_slot_freed;

  // f0 is hardwired when ZERO_R0 is set: writes to it never land.
  assign w_wb_eff     = i_wb_en & ~(ZERO_R0 & (i_wb_addr == '0));
  // A writeback to a saturated destination frees a slot in the same cycle.
  assign w_slot_freed = i_wb_en & (i_wb_addr == i_iss_addr);
  assign o_iss_ok     = ~i_iss_en | ~w_sat[i_iss_addr] | w_slot_freed;
  assign o_err        = r_err;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
    localparam bit R_FIXED = ZERO_R0 && (g == 0);

    assign w_inc[g] = i_iss_en & o_iss_ok & (i_iss_addr == ADDR_W'(g)) & ~R_FIXED;
    assign w_dec[g] = i_wb_en & (i_wb_addr == ADDR_W'(g)) & ~R_FIXED;

    fp_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_inc       (w_inc[g]),
      .i_dec       (w_dec[g]),
      .o_cnt       (w_pend[g]),
      .o_sat       (w_sat[g]),
      .o_zero      (w_zero[g]),
      .o_underflow (w_unf[g])
    );
  end

  function automatic logic [DATA_W-1:0] f_rd_data(input logic [ADDR_W-1:0] a);
    if (ZERO_R0 && a == '0)                           return '0;
    if (FORWARD_EN && i_wb_en && i_wb_addr == a)      return i_wb_data;
    return r_regs[a];
  endfunction

  function automatic logic f_rd_rdy(input logic [ADDR_W-1:0] a);
    if (!i_rd_en)                                     return 1'b1;
    if (ZERO_R0 && a == '0)                           return 1'b1;
    if (w_zero[a])                                    return 1'b1;
    return FORWARD_EN && (w_pend[a] == PEND_W'(1)) && i_wb_en && (i_wb_addr == a);
  endfunction

  assign o_rd_data_1 = f_rd_data(i_rd_addr_1);
  assign o_rd_data_2 = f_rd_data(i_rd_addr_2);
  assign o_rd_rdy_1  = f_rd_rdy(i_rd_addr_1);
  assign o_rd_rdy_2  = f_rd_rdy(i_rd_addr_2);

  // Register array: clear on reset, otherwise capture writeback data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wb_eff) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  // Sticky flag for a writeback that had no matching issue.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (|w_unf) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_reg_file_sb.sv
// Self-checking bench for fp_reg_file_sb with default parameters.
module tb_fp_reg_file_sb;
  import fp_rf_pkg::*;

  localparam int K_D1 = 0, K_D2 = 1, K_R1 = 2, K_R2 = 3, K_OK = 4, K_ERR = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic [4:0]  ra1 = '0, ra2 = '0;
  logic [31:0] rd1, rd2;
  logic        rdy1, rdy2;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic        iss_ok;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          rst;
    bit          rd_en;
    logic [4:0]  a1;
    logic [4:0]  a2;
    bit          iss;
    logic [4:0]  ia;
    bit          wb;
    logic [4:0]  wa;
    logic [31:0] wd;
  } stim_t;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       tag;
  } exp_t;

  stim_t st[$];
  exp_t  sb[$];

  fp_reg_file_sb dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rd_en     (rd_en),
    .i_rd_addr_1 (ra1),
    .i_rd_addr_2 (ra2),
    .o_rd_data_1 (rd1),
    .o_rd_data_2 (rd2),
    .o_rd_rdy_1  (rdy1),
    .o_rd_rdy_2  (rdy2),
    .i_iss_en    (iss_en),
    .i_iss_addr  (iss_addr),
    .o_iss_ok    (iss_ok),
    .i_wb_en     (wb_en),
    .i_wb_addr   (wb_addr),
    .i_wb_data   (wb_data),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void cyc(bit r, bit re, int a1, int a2, bit is, int ia,
                              bit w, int wa, logic [31:0] wd);
    stim_t s;
    s.rst = r; s.rd_en = re; s.a1 = 5'(a1); s.a2 = 5'(a2);
    s.iss = is; s.ia = 5'(ia); s.wb = w; s.wa = 5'(wa); s.wd = wd;
    st.push_back(s);
  endfunction

  function automatic void ex(int k, logic [31:0] v, string t);
    exp_t e;
    e.cyc = st.size() - 1; e.kind = k; e.val = v; e.tag = t;
    sb.push_back(e);
  endfunction

  function automatic logic [31:0] obs(int k);
    case (k)
      K_D1:    return rd1;
      K_D2:    return rd2;
      K_R1:    return {31'b0, rdy1};
      K_R2:    return {31'b0, rdy2};
      K_OK:    return {31'b0, iss_ok};
      default: return {31'b0, err};
    endcase
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; rd_en = s.rd_en; ra1 = s.a1; ra2 = s.a2;
    iss_en = s.iss; iss_addr = s.ia; wb_en = s.wb; wb_addr = s.wa; wb_data = s.wd;
  endtask

  task automatic test_reset();
    exp_t e;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 2, 0, 0, 0, 0, 0);
    ex(K_D1, 0, "reset_rd1"); ex(K_D2, 0, "reset_rd2");
    ex(K_R1, 1, "reset_rdy1"); ex(K_R2, 1, "reset_rdy2");
    ex(K_OK, 1, "reset_iss_ok"); ex(K_ERR, 0, "reset_err");
    for (int c = 0; c < st.size(); c++) begin
      @(negedge clk); drive(st[c]); #2;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); checks++;
        if (obs(e.kind) !== e.val) begin
          failures++;
          $display("FAIL %s: actual=%h required=%h", e.tag, obs(e.kind), e.val);
        end
      end
    end
    st.delete();
  endtask

  task automatic test_write_bypass();
    exp_t e;
    cyc(0, 0, 0, 0, 1, 3, 0, 0, 0);
    ex(K_OK, 1, "wr_iss_f3");
    cyc(0, 1, 3, 0, 0, 0, 1, 3, 32'h3F99_999A);
    ex(K_D1, 32'h3F99_999A, "wr_bypass_data"); ex(K_R1, 1, "wr_bypass_rdy");
    cyc(0, 1, 3, 0, 0, 0, 0, 0, 0);
    ex(K_D1, 32'h3F99_999A, "wr_array_data"); ex(K_R1, 1, "wr_array_rdy");
    ex(K_ERR, 0, "wr_err");
    for (int c = 0; c < st.size(); c++) begin
      @(negedge clk); drive(st[c]); #2;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); checks++;
        if (obs(e.kind) !== e.val) begin
          failures++;
          $display("FAIL %s: actual=%h required=%h", e.tag, obs(e.kind), e.val);
        end
      end
    end
    st.delete();
  endtask

  task automatic test_pending();
    exp_t e;
    cyc(0, 0, 0, 0, 1, 5, 0, 0, 0);
    ex(K_OK, 1, "pend_iss_f5");
    cyc(0, 1, 0, 5, 0, 0, 0, 0, 0);
    ex(K_R2, 0, "pend_rdy2_busy");
    cyc(0, 0, 0, 5, 0, 0, 0, 0, 0);
    ex(K_R2, 1, "pend_rdy2_rd_en_low");
    cyc(0, 1, 0, 5, 0, 0, 1, 5, 32'h4000_0000);
    ex(K_R2, 1, "pend_rdy2_fwd"); ex(K_D2, 32'h4000_0000, "pend_data2_fwd");
    cyc(0, 1, 0, 5, 0, 0, 0, 0, 0);
    ex(K_R2, 1, "pend_rdy2_done"); ex(K_D2, 32'h4000_0000, "pend_data2_arr");
    ex(K_ERR, 0, "pend_err");
    for (int c = 0; c < st.size(); c++) begin
      @(negedge clk); drive(st[c]); #2;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); checks++;
        if (obs(e.kind) !== e.val) begin
          failures++;
          $display("FAIL %s: actual=%h required=%h", e.tag, obs(e.kind), e.val);
        end
      end
    end
    st.delete();
  endtask

  task automatic test_saturate();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 7, 0, 0, 0);
      ex(K_OK, 1, $sformatf("sat_iss_%0d", i));
    end
    cyc(0, 1, 7, 0, 1, 7, 0, 0, 0);
    ex(K_OK, 0, "sat_iss_4th_reject"); ex(K_R1, 0, "sat_rdy1_busy");
    cyc(0, 1, 7, 0, 1, 7, 1, 7, FP_ONE);
    ex(K_OK, 1, "sat_iss_with_wb"); ex(K_R1, 0, "sat_rdy1_cnt3_wb");
    cyc(0, 0, 0, 0, 1, 7, 0, 0, 0);
    ex(K_OK, 0, "sat_cnt_held_3");
    cyc(0, 0, 0, 0, 0, 0, 1, 7, FP_ONE);
    cyc(0, 0, 0, 0, 0, 0, 1, 7, FP_ONE);
    cyc(0, 1, 7, 0, 0, 0, 1, 7, 32'h4040_0000);
    ex(K_R1, 1, "sat_rdy1_last_fwd"); ex(K_D1, 32'h4040_0000, "sat_data1_fwd");
    cyc(0, 1, 7, 0, 1, 7, 0, 0, 0);
    ex(K_R1, 1, "sat_rdy1_drained"); ex(K_D1, 32'h4040_0000, "sat_data1_arr");
    ex(K_OK, 1, "sat_iss_after_drain"); ex(K_ERR, 0, "sat_err");
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 32'h4040_0000);
    for (int c = 0; c < st.size(); c++) begin
      @(negedge clk); drive(st[c]); #2;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); checks++;
        if (obs(e.kind) !== e.val) begin
          failures++;
          $display("FAIL %s: actual=%h required=%h", e.tag, obs(e.kind), e.val);
        end
      end
    end
    st.delete();
  endtask

  task automatic test_underflow();
    exp_t e;
    cyc(0, 1, 0, 9, 0, 0, 1, 9, 32'hC0A0_0000);
    ex(K_ERR, 0, "unf_err_before_edge"); ex(K_D2, 32'hC0A0_0000, "unf_data2_fwd");
    cyc(0, 1, 0, 9, 0, 0, 0, 0, 0);
    ex(K_ERR, 1, "unf_err_set"); ex(K_D2, 32'hC0A0_0000, "unf_data2_written");
    ex(K_R2, 1, "unf_rdy2");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex(K_ERR, 1, "unf_err_sticky");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 9, 3, 0, 0, 0, 0, 0);
    ex(K_ERR, 0, "unf_err_cleared"); ex(K_D1, 0, "unf_f9_cleared");
    ex(K_D2, 0, "unf_f3_cleared"); ex(K_R1, 1, "unf_rdy1_after_rst");
    cyc(0, 0, 0, 0, 1, 12, 1, 12, 32'h4120_0000);
    ex(K_OK, 1, "unf_iss_wb_same_f12");
    cyc(0, 1, 12, 0, 0, 0, 0, 0, 0);
    ex(K_R1, 1, "unf_f12_rdy"); ex(K_D1, 32'h4120_0000, "unf_f12_data");
    ex(K_ERR, 0, "unf_iss_wb_no_err");
    for (int c = 0; c < st.size(); c++) begin
      @(negedge clk); drive(st[c]); #2;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); checks++;
        if (obs(e.kind) !== e.val) begin
          failures++;
          $display("FAIL %s: actual=%h required=%h", e.tag, obs(e.kind), e.val);
        end
      end
    end
    st.delete();
  endtask

  task automatic test_reset_override();
    exp_t e;
    cyc(0, 0, 0, 0, 1, 4, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 4, 1, 4, FP_ONE);
    cyc(0, 1, 4, 4, 0, 0, 0, 0, 0);
    ex(K_D1, 0, "rovr_f4_data1"); ex(K_D2, 0, "rovr_f4_data2");
    ex(K_R1, 1, "rovr_f4_rdy1"); ex(K_R2, 1, "rovr_f4_rdy2");
    ex(K_ERR, 0, "rovr_err");
    for (int c = 0; c < st.size(); c++) begin
      @(negedge clk); drive(st[c]); #2;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); checks++;
        if (obs(e.kind) !== e.val) begin
          failures++;
          $display("FAIL %s: actual=%h required=%h", e.tag, obs(e.kind), e.val);
        end
      end
    end
    st.delete();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] v [4];
    for (int i = 0; i < 4; i++) v[i] = $urandom();
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 10 + i, 0, 1, 10 + i, 0, 0, 0);
      ex(K_OK, 1, $sformatf("b2b_iss_f%0d", 10 + i));
      ex(K_R1, 1, $sformatf("b2b_rdy_pre_f%0d", 10 + i));
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 10 + i, (i > 0) ? 9 + i : 13, 0, 0, 1, 10 + i, v[i]);
      ex(K_D1, v[i], $sformatf("b2b_fwd_f%0d", 10 + i));
      ex(K_R1, 1, $sformatf("b2b_rdy_fwd_f%0d", 10 + i));
      if (i > 0) begin
        ex(K_D2, v[i-1], $sformatf("b2b_arr_f%0d", 9 + i));
        ex(K_R2, 1, $sformatf("b2b_rdy_arr_f%0d", 9 + i));
      end else begin
        ex(K_R2, 0, "b2b_f13_busy");
      end
    end
    cyc(0, 1, 13, 10, 0, 0, 0, 0, 0);
    ex(K_D1, v[3], "b2b_final_f13"); ex(K_D2, v[0], "b2b_final_f10");
    ex(K_ERR, 0, "b2b_err");
    for (int c = 0; c < st.size(); c++) begin
      @(negedge clk); drive(st[c]); #2;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); checks++;
        if (obs(e.kind) !== e.val) begin
          failures++;
          $display("FAIL %s: actual=%h required=%h", e.tag, obs(e.kind), e.val);
        end
      end
    end
    st.delete();
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_pending();
    test_saturate();
    test_underflow();
    test_reset_override();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
